// File: rtl/squish_scheduler_if.sv
// Request/result bundle between the neuron requesters, the shared squish
// scheduler and the layer sequencer.
//   master : the scheduler (issues acks, produces tagged results)
//   slave  : the requester/consumer side
interface squish_scheduler_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]    req;
    logic [N_REQ*33-1:0] req_data;
    logic [N_REQ-1:0]    ack;
    logic                res_valid;
    logic                res_ready;
    logic [ID_W-1:0]     res_id;
    logic [16:0]         res_data;

    modport master (
        input  req, req_data, res_ready,
        output ack, res_valid, res_id, res_data
    );

    modport slave (
        output req, req_data, res_ready,
        input  ack, res_valid, res_id, res_data
    );
endinterface

// File: rtl/squish_scheduler.sv
// squish_scheduler: round-robin time-multiplexing of one shared squish
// activation datapath across N_REQ neuron requesters. Each grant registers
// the winner's 33-bit pre-activation into sq_in, captures the 17-bit result
// one cycle later and presents it tagged with the requester index.
// Optional build macro SQUISH_STATS_EN adds a 16-bit completed-result
// counter on port op_count.
module squish_scheduler #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    squish_scheduler_if.master  bus,
    output logic [32:0]         sq_in,
    input  logic [16:0]         sq_out
`ifdef SQUISH_STATS_EN
    ,
    output logic [15:0]         op_count
`endif
);

    typedef enum logic [1:0] {IDLE, CALC, RESULT} state_t;

    state_t          state, state_nxt;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] win;
    logic [ID_W-1:0] ptr_nxt;
    logic [ID_W:0]   cand;
    logic            grant_ok;
    logic [32:0]     sel_data;
    logic            grant;
    logic            capture;
    logic            drop_res;

    // Round-robin search: first set req at or above rr_ptr, wrapping to 0.
    // Loop runs from the farthest offset down so the nearest one wins.
    always_comb begin
        grant_ok = 1'b0;
        win      = '0;
        cand     = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = {1'b0, rr_ptr} + (ID_W + 1)'(i);
            if (cand >= (ID_W + 1)'(N_REQ))
                cand = cand - (ID_W + 1)'(N_REQ);
            if (bus.req[cand[ID_W-1:0]]) begin
                grant_ok = 1'b1;
                win      = cand[ID_W-1:0];
            end
        end
    end

    // Winner's operand slice and the pointer value that follows it.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win == ID_W'(i))
                sel_data = bus.req_data[33*i +: 33];
        end
        ptr_nxt = ({1'b0, win} == (ID_W + 1)'(N_REQ - 1)) ? '0 : win + 1'b1;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and per-edge actions; a result handshake with requests
    // pending re-grants on the same edge so results can issue every 2 cycles.
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        capture   = 1'b0;
        drop_res  = 1'b0;
        case (state)
            IDLE: begin
                if (grant_ok) begin
                    grant     = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                capture   = 1'b1;
                state_nxt = RESULT;
            end
            RESULT: begin
                if (bus.res_valid && bus.res_ready) begin
                    drop_res = 1'b1;
                    if (grant_ok) begin
                        grant     = 1'b1;
                        state_nxt = CALC;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand launch, ack pulse, result capture and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sq_in         <= '0;
            rr_ptr        <= '0;
            bus.ack       <= '0;
            bus.res_valid <= 1'b0;
            bus.res_id    <= '0;
            bus.res_data  <= '0;
        end else begin
            bus.ack <= '0;
            if (grant) begin
                bus.ack    <= N_REQ'(1) << win;
                sq_in      <= sel_data;
                bus.res_id <= win;
                rr_ptr     <= ptr_nxt;
            end
            if (capture) begin
                bus.res_data  <= sq_out;
                bus.res_valid <= 1'b1;
            end
            if (drop_res)
                bus.res_valid <= 1'b0;
        end
    end

`ifdef SQUISH_STATS_EN
    // Completed-result counter; wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (!reset_n)
            op_count <= '0;
        else if (drop_res)
            op_count <= op_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_squish_scheduler.sv
// Directed bench for squish_scheduler. The shared datapath is stood in for by
// a simple model: sq_out = {sign, popcount(sq_in[31:0])}.
module tb_squish_scheduler;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [32:0] sq_in;
    logic [16:0] sq_out;
`ifdef SQUISH_STATS_EN
    logic [15:0] op_count;
`endif

    int checks = 0;
    int errors = 0;

    squish_scheduler_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus ();

    squish_scheduler #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus.master),
        .sq_in    (sq_in),
        .sq_out   (sq_out)
`ifdef SQUISH_STATS_EN
        ,
        .op_count (op_count)
`endif
    );

    always #5 clk = ~clk;

    assign sq_out = {sq_in[32], 16'($countones(sq_in[31:0]))};

    typedef struct {
        logic [3:0]   req;
        logic [131:0] data;
        logic [1:0]   id;
        logic [16:0]  res;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One isolated transaction from IDLE with res_ready high.
    task automatic run_one(input logic [3:0] r, input logic [131:0] d,
                           input logic [1:0] id, input logic [16:0] res);
        logic [32:0] slice;
        slice = d[33*id +: 33];
        bus.req       = r;
        bus.req_data  = d;
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        chk("grant_ack", 64'(bus.ack), 64'(4'b0001 << id));
        chk("grant_sq_in", 64'(sq_in), 64'(slice));
        chk("grant_no_valid", 64'(bus.res_valid), 64'd0);
        bus.req = '0;
        @(posedge clk); #1;
        chk("calc_ack_low", 64'(bus.ack), 64'd0);
        chk("res_valid", 64'(bus.res_valid), 64'd1);
        chk("res_id", 64'(bus.res_id), 64'(id));
        chk("res_data", 64'(bus.res_data), 64'(res));
        @(posedge clk); #1;
        chk("res_drop", 64'(bus.res_valid), 64'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    logic [16:0]  rr_res [4];
    logic [131:0] rr_data;
    logic [131:0] bp_data;

    initial begin
        // req, {slice3,slice2,slice1,slice0}, expected id, expected result
        tbl[0] = '{4'b0001, {33'h0, 33'h0, 33'h0, 33'h0_0000_000C}, 2'd0, 17'h00002};
        tbl[1] = '{4'b0100, {33'h0, 33'h1_0000_0001, 33'h0, 33'h0}, 2'd2, 17'h10001};
        tbl[2] = '{4'b0011, {33'h0, 33'h0, 33'h1_FFFF_FFFF, 33'h0_0000_00FF}, 2'd0, 17'h00008};
        tbl[3] = '{4'b0011, {33'h0, 33'h0, 33'h1_FFFF_FFFF, 33'h0_0000_00FF}, 2'd1, 17'h10020};
        tbl[4] = '{4'b1001, {33'h0_8000_0000, 33'h0, 33'h0, 33'h0_0000_0001}, 2'd3, 17'h00001};
        tbl[5] = '{4'b1000, {33'h1_0000_0000, 33'h0, 33'h0, 33'h0}, 2'd3, 17'h10000};
        tbl[6] = '{4'b0110, {33'h0, 33'h0_0000_0003, 33'h0_0F0F_0F0F, 33'h0}, 2'd1, 17'h00010};

        rr_data   = {33'h1_0000_000F, 33'h0_FFFF_0000, 33'h1_0000_0007, 33'h0_0000_0003};
        rr_res[0] = 17'h00002;
        rr_res[1] = 17'h10003;
        rr_res[2] = 17'h00010;
        rr_res[3] = 17'h10004;
        bp_data   = {33'h0, 33'h0, 33'h1_0000_0001, 33'h0_0000_000C};

        bus.req       = '0;
        bus.req_data  = '0;
        bus.res_ready = 1'b0;
        do_reset();

        chk("rst_ack", 64'(bus.ack), 64'd0);
        chk("rst_valid", 64'(bus.res_valid), 64'd0);
        chk("rst_id", 64'(bus.res_id), 64'd0);
        chk("rst_data", 64'(bus.res_data), 64'd0);
        chk("rst_sq_in", 64'(sq_in), 64'd0);

        // Round robin: all four requesting, each drops after its ack.
        bus.req       = 4'b1111;
        bus.req_data  = rr_data;
        bus.res_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("rr_ack", 64'(bus.ack), 64'(4'b0001 << k));
            bus.req[k] = 1'b0;
            @(posedge clk); #1;
            chk("rr_valid", 64'(bus.res_valid), 64'd1);
            chk("rr_id", 64'(bus.res_id), 64'(k));
            chk("rr_data", 64'(bus.res_data), 64'(rr_res[k]));
        end
        @(posedge clk); #1;
        chk("rr_idle", 64'(bus.res_valid), 64'd0);

        // Restart with 1001 from rr_ptr 0: grants 0 then 3 back to back.
        bus.req = 4'b1001;
        @(posedge clk); #1;
        chk("rr2_ack0", 64'(bus.ack), 64'(4'b0001));
        bus.req = 4'b1000;
        @(posedge clk); #1;
        chk("rr2_id0", 64'(bus.res_id), 64'd0);
        @(posedge clk); #1;
        chk("rr2_ack3", 64'(bus.ack), 64'(4'b1000));
        chk("rr2_valid_clr", 64'(bus.res_valid), 64'd0);
        bus.req = '0;
        @(posedge clk); #1;
        chk("rr2_id3", 64'(bus.res_id), 64'd3);
        chk("rr2_data3", 64'(bus.res_data), 64'(rr_res[3]));
        @(posedge clk); #1;
        chk("rr2_idle", 64'(bus.res_valid), 64'd0);

        // Backpressure: result held, pending request not acked until ready.
        bus.req      = 4'b0001;
        bus.req_data = bp_data;
        @(posedge clk); #1;
        chk("bp_ack0", 64'(bus.ack), 64'(4'b0001));
        bus.req       = '0;
        bus.res_ready = 1'b0;
        @(posedge clk); #1;
        chk("bp_valid", 64'(bus.res_valid), 64'd1);
        bus.req = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", 64'(bus.res_valid), 64'd1);
            chk("bp_hold_id", 64'(bus.res_id), 64'd0);
            chk("bp_hold_data", 64'(bus.res_data), 64'(17'h00002));
            chk("bp_no_ack", 64'(bus.ack), 64'd0);
        end
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_ack1", 64'(bus.ack), 64'(4'b0010));
        chk("bp_valid_clr", 64'(bus.res_valid), 64'd0);
        bus.req = '0;
        @(posedge clk); #1;
        chk("bp_id1", 64'(bus.res_id), 64'd1);
        chk("bp_data1", 64'(bus.res_data), 64'(17'h10001));
        @(posedge clk); #1;
        chk("bp_idle", 64'(bus.res_valid), 64'd0);

        // Reset during CALC discards the in-flight operation.
        bus.req      = 4'b0100;
        bus.req_data = tbl[1].data;
        @(posedge clk); #1;
        chk("mid_ack", 64'(bus.ack), 64'(4'b0100));
        reset_n = 1'b0;
        bus.req = '0;
        @(posedge clk); #1;
        chk("mid_valid", 64'(bus.res_valid), 64'd0);
        chk("mid_ack_clr", 64'(bus.ack), 64'd0);
        chk("mid_rr_ptr", 64'(dut.rr_ptr), 64'd0);
        chk("mid_data", 64'(bus.res_data), 64'd0);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("mid_no_result", 64'(bus.res_valid), 64'd0);
        end

        // Table-driven isolated transactions starting from rr_ptr 0.
        for (int v = 0; v < 7; v++)
            run_one(tbl[v].req, tbl[v].data, tbl[v].id, tbl[v].res);

`ifdef SQUISH_STATS_EN
        do_reset();
        chk("stats_rst", 64'(op_count), 64'd0);
        for (int k = 0; k < 3; k++)
            run_one(tbl[0].req, tbl[0].data, tbl[0].id, tbl[0].res);
        chk("stats_three", 64'(op_count), 64'd3);
        force dut.op_count = 16'hFFFF;
        #1;
        release dut.op_count;
        run_one(tbl[0].req, tbl[0].data, tbl[0].id, tbl[0].res);
        chk("stats_wrap", 64'(op_count), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/squish_scheduler.md
Name: squish_scheduler

Overview:
- Time-multiplexes one shared `squish` activation datapath (33-bit pre-activation in, 17-bit squashed out) across N_REQ neuron requesters in the XOR network.
- Round-robin arbitration with a per-requester req/ack handshake.
- Registers the operand into the datapath and captures its output.
- Returns each result tagged with the requester index over a valid/ready interface to the layer sequencer.

Parameters:
- N_REQ, 4, number of neuron requesters (2..16).
- ID_W, 2, width of the requester index; must satisfy 2^ID_W >= N_REQ.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- req  in  N_REQ  per-requester activation request.
- req_data  in  N_REQ*33  pre-activation sums; requester i occupies bits [33*i+32 : 33*i], and bit 32 of each slice is the sign.
- ack  out  N_REQ  one-cycle grant pulse to the chosen requester.
- sq_in  out  33  registered operand driven into the squish datapath.
- sq_out  in  17  combinational result returned from the squish datapath.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_id  out  ID_W  index of the requester that owns the result.
- res_data  out  17  captured squish result.

Behaviour:
- Reset (reset_n low at a rising edge) clears all of the following:
  - state to IDLE
  - sq_in, res_data, res_id to 0
  - res_valid to 0, ack to all-zero
  - rr_ptr to 0
- Reset mid-operation discards any in-flight operand or result. No ack or res_valid is produced for it.
- The FSM has three states: IDLE, CALC, RESULT.
- IDLE:
  - If req is non-zero, select the winner by round-robin: the first set bit searching upward from rr_ptr and wrapping at N_REQ-1 -> 0.
  - At the same edge:
    - latch that requester's slice into sq_in;
    - latch its index into res_id;
    - set rr_ptr to winner+1 (wrapping to 0 past N_REQ-1);
    - register ack[winner]=1;
    - go to CALC.
  - If req is zero, remain in IDLE.
- CALC:
  - ack is high for exactly this cycle.
  - sq_out settles from sq_in during this cycle.
  - At the end of the cycle, capture sq_out into res_data, set res_valid=1 and go to RESULT.
- RESULT:
  - res_valid, res_id and res_data are held stable until res_valid && res_ready.
  - On the handshake edge with req non-zero: perform the IDLE grant actions in the same edge (back-to-back issue), clear res_valid and go to CALC.
  - On the handshake edge with req zero: clear res_valid and go to IDLE.
  - If res_ready is low, remain in RESULT indefinitely (backpressure).
- Latency: grant edge to res_valid = 2 edges; ack and res_valid never overlap for the same transaction.
- Throughput: one result per 2 cycles with res_ready tied high. An isolated request costs 3 cycles (IDLE, CALC, RESULT).
- Requester rules:
  - Hold req and req_data stable until ack is seen.
  - Deassert req no later than the edge following ack.
  - The next grant decision is at least 2 edges after ack, so a requester that drops req on time is never double-granted.
- Simultaneous requests: exactly one ack per grant; losers keep req asserted and are served in rotation order.
- Starvation bound: any asserted req is granted within N_REQ grants.
- No arithmetic is performed here; sq_in and res_data are pass-through widths 33 and 17.
- sq_in holds its last value outside CALC. sq_in only changes on a grant edge.

Optional Feature:
- Macro SQUISH_STATS_EN.
- When defined:
  - adds output port op_count (16 bits, reset 0);
  - op_count increments by 1 on each res_valid && res_ready edge and wraps 16'hFFFF -> 0;
  - a simultaneous reset wins over the increment.
- When undefined: the op_count port and its counter are absent; all other behaviour is identical.

Test Plan:
- Single request: req=4'b0001, slice0=33'h0_0000_000C, res_ready=1 -> ack[0] pulses one cycle after the grant edge; res_valid 2 edges after grant; res_id=0, res_data=17'h00002.
- Sign passthrough: req=4'b0100, slice2=33'h1_0000_0001 -> res_id=2, res_data=17'h10001.
- Round-robin fairness:
  - req=4'b1111 held, with each requester dropping its req after its ack;
  - expected grant order 0,1,2,3;
  - restarting with req=4'b1001 from rr_ptr=0 -> grants 0 then 3.
- Backpressure: hold res_ready=0 for 5 cycles in RESULT with req=4'b0010 pending -> res_valid/res_id/res_data stable and no ack; raising res_ready grants requester 1 at the handshake edge.
- Reset mid-operation: assert reset_n=0 during CALC -> next cycle res_valid=0, ack=0, rr_ptr=0; the in-flight result never appears.
- With SQUISH_STATS_EN: 3 completed handshakes -> op_count=3; force the counter to 16'hFFFF, complete one more handshake -> op_count=0.
